// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Used by uart_tx_arbiter and rr_pick.
package uart_arb_pkg;

    localparam int unsigned MAX_N_REQ = 8;
    localparam logic [7:0]  UART_EOL  = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SEND    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// The search starts at i_last+1 and wraps from N_REQ-1 to 0.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic        w_found;
    int unsigned w_cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_cand = (int'(i_last) + k) % N_REQ;
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte streams.
// Optional line locking is enabled by defining UART_ARB_LINE_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 80
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [N_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_last;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;

    logic [N_REQ-1:0]   w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_sel_valid;
    logic [7:0]         w_sel_data;
    logic               w_lock;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx)
    );

    assign w_sel_valid = req_valid[r_gidx];
    assign w_sel_data  = req_data[{r_gidx, 3'b000} +: 8];

`ifdef UART_ARB_LINE_LOCK_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] r_burst_cnt;

    // Counter saturates at the limit so a huge MAX_BURST can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else if (r_state == ST_RELEASE) begin
            r_burst_cnt <= '0;
        end else if (r_state == ST_LOAD && w_sel_valid && r_burst_cnt != BURST_LIMIT) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    assign w_lock = (r_tx_data != UART_EOL) && (r_burst_cnt < BURST_LIMIT) && w_sel_valid;
`else
    assign w_lock = 1'b0;
`endif

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_sel_valid) begin
                    req_ready   = r_grant;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_SEND: begin
                if (tx_data_ready) begin
                    w_state_nxt = w_lock ? ST_LOAD : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath; the byte register is reset too so the transmitter never sees X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_gidx     <= '0;
            r_last     <= IDX_W'(N_REQ - 1);
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_grant <= w_pick_gnt;
                        r_gidx  <= w_pick_idx;
                    end
                end
                ST_LOAD: begin
                    if (w_sel_valid) begin
                        r_tx_data  <= w_sel_data;
                        r_tx_valid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (tx_data_ready) begin
                        r_tx_valid <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    r_last  <= r_gidx;
                    r_grant <= '0;
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign tx_data       = r_tx_data;
    assign tx_data_valid = r_tx_valid;
    assign grant         = r_grant;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester streams, expected
// (owner, byte) pairs queued at stimulus time and checked by a transfer monitor.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_data_valid;
    logic             tx_data_ready;
    logic [N-1:0]     grant;
    logic             busy;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rq_q[N][$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    uart_tx_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (rq_q[i].size() > 0);
            req_data[8*i +: 8] = (rq_q[i].size() > 0) ? rq_q[i][0] : 8'h00;
        end
    endtask

    task automatic push(input int r, input logic [7:0] b);
        rq_q[r].push_back(b);
        drive();
    endtask

    task automatic exp_push(input int r, input logic [7:0] b);
        exp_t e;
        e.idx  = 2'(r);
        e.data = b;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) rq_q[i].delete();
        exp_q.delete();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int r, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (grant[r]) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_tx_valid(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (tx_data_valid) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy && (req_valid == '0);
        end
        check(name, 32'(done), 32'd1);
    endtask

    // Requester model: a byte leaves its queue once req_ready was seen.
    initial begin
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (acc[i] && rq_q[i].size() > 0) void'(rq_q[i].pop_front());
            drive();
        end
    end

    // Transfer monitor: every accepted byte is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && tx_data_valid && tx_data_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_grant", 32'(grant), 32'(1 << e.idx));
                    check("sb_data", 32'(tx_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        bit stable;
        rst_n         = 1'b0;
        tx_data_ready = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        drive();
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_valid", 32'(tx_data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Single byte from idle with the transmitter always ready.
        @(posedge clk); #2;
        push(0, 8'h41);
        exp_push(0, 8'h41);
        @(negedge clk);
        check("t1_idle_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("t1_load_ready", 32'(req_ready), 32'b0001);
        check("t1_load_grant", 32'(grant), 32'b0001);
        check("t1_load_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_send_valid", 32'(tx_data_valid), 32'd1);
        check("t1_send_data", 32'(tx_data), 32'h41);
        check("t1_send_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("t1_rel_grant", 32'(grant), 32'b0001);
        @(negedge clk);
        check("t1_idle_grant", 32'(grant), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Three requesters valid together.
        do_reset();
        @(posedge clk); #2;
        push(0, 8'h10); push(0, 8'h11);
        push(1, 8'h20); push(1, 8'h21);
        push(2, 8'h30); push(2, 8'h31);
`ifdef UART_ARB_LINE_LOCK_EN
        exp_push(0, 8'h10); exp_push(0, 8'h11);
        exp_push(1, 8'h20); exp_push(1, 8'h21);
        exp_push(2, 8'h30); exp_push(2, 8'h31);
`else
        exp_push(0, 8'h10); exp_push(1, 8'h20); exp_push(2, 8'h30);
        exp_push(0, 8'h11); exp_push(1, 8'h21); exp_push(2, 8'h31);
`endif
        wait_drain("rr_drain");

        // Requester 1 sends a line while requester 2 waits.
        do_reset();
        @(posedge clk); #2;
        push(1, 8'h41); push(1, 8'h42); push(1, 8'h0A);
        push(2, 8'h55);
`ifdef UART_ARB_LINE_LOCK_EN
        exp_push(1, 8'h41); exp_push(1, 8'h42); exp_push(1, 8'h0A);
        exp_push(2, 8'h55);
`else
        exp_push(1, 8'h41); exp_push(2, 8'h55);
        exp_push(1, 8'h42); exp_push(1, 8'h0A);
`endif
        wait_drain("line_drain");

        // Requester 3 streams ten bytes without end of line; requester 0 joins.
        do_reset();
        @(posedge clk); #2;
        for (int i = 0; i < 10; i++) push(3, 8'(8'h60 + i));
        wait_grant(3, "burst_first_grant");
        push(0, 8'h77);
`ifdef UART_ARB_LINE_LOCK_EN
        for (int i = 0; i < 4; i++) exp_push(3, 8'(8'h60 + i));
        exp_push(0, 8'h77);
        for (int i = 4; i < 10; i++) exp_push(3, 8'(8'h60 + i));
`else
        exp_push(3, 8'h60);
        exp_push(0, 8'h77);
        for (int i = 1; i < 10; i++) exp_push(3, 8'(8'h60 + i));
`endif
        wait_drain("burst_drain");

        // Transmitter stalls for 50 cycles during SEND.
        do_reset();
        tx_data_ready = 1'b0;
        @(posedge clk); #2;
        push(2, 8'hC3);
        exp_push(2, 8'hC3);
        wait_grant(2, "stall_grant");
        push(1, 8'h5A);
        exp_push(1, 8'h5A);
        wait_tx_valid("stall_valid_seen");
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx_data !== 8'hC3 || tx_data_valid !== 1'b1 || req_ready !== '0) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_grant_held", 32'(grant), 32'b0100);
        @(posedge clk); #2;
        tx_data_ready = 1'b1;
        wait_drain("stall_drain");

        // Reset asserted while a byte is pending.
        do_reset();
        tx_data_ready = 1'b0;
        @(posedge clk); #2;
        push(0, 8'h99);
        wait_tx_valid("rst_mid_valid_seen");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", 32'(tx_data_valid), 32'd0);
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        for (int i = 0; i < N; i++) rq_q[i].delete();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_data_ready = 1'b1;
        @(posedge clk); #2;
        push(0, 8'hA0);
        push(1, 8'hB1);
        exp_push(0, 8'hA0);
        exp_push(1, 8'hB1);
        begin
            bit ok = 1'b0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(negedge clk);
                if (grant != '0) ok = 1'b1;
            end
            check("rst_after_first_grant", 32'(grant), 32'b0001);
        end
        wait_drain("rst_after_drain");

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
